// File: rtl/vga_dbg_pkg.sv
// rtl/vga_dbg_pkg.sv - shared types and helpers for the VGA debug memory scanner
package vga_dbg_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SCAN  = 2'd1,
        DRAIN = 2'd2
    } scan_state_e;

    localparam logic MEM_SEL_ROM = 1'b0;
    localparam logic MEM_SEL_RAM = 1'b1;

    // Display buffer index is {sel, page, word}
    function automatic int BUF_IDX_W(input int words);
        return $clog2(words) + 2;
    endfunction

endpackage

// File: rtl/vga_rd_tag_pipe.sv
// rtl/vga_rd_tag_pipe.sv - DEPTH-deep valid+tag shift register tracking in-flight reads
module vga_rd_tag_pipe #(
    parameter int DEPTH = 1,
    parameter int TAG_W = 8
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             valid_i,
    input  logic [TAG_W-1:0] tag_i,
    output logic             valid_o,
    output logic [TAG_W-1:0] tag_o,
    output logic             pending_o
);

    logic [DEPTH-1:0] vld_q;
    logic [TAG_W-1:0] tag_q [DEPTH];

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            vld_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                tag_q[i] <= '0;
            end
        end else begin
            vld_q[0] <= valid_i;
            tag_q[0] <= tag_i;
            for (int i = 1; i < DEPTH; i++) begin
                vld_q[i] <= vld_q[i-1];
                tag_q[i] <= tag_q[i-1];
            end
        end
    end

    assign valid_o = vld_q[DEPTH-1];
    assign tag_o   = tag_q[DEPTH-1];

    // Reads still travelling behind the tail stage; the tail itself completes this cycle
    generate
        if (DEPTH > 1) begin : g_pend
            assign pending_o = |vld_q[DEPTH-2:0];
        end else begin : g_nopend
            assign pending_o = 1'b0;
        end
    endgenerate

endmodule

// File: rtl/vga_mem_scan_arbiter.sv
// rtl/vga_mem_scan_arbiter.sv - shares the debug read port between CPU and a per-frame buffer scanner
module vga_mem_scan_arbiter
    import vga_dbg_pkg::*;
#(
    parameter int WORDS      = 64,
    parameter int RD_LAT     = 1,
    parameter int STARVE_MAX = 16
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    input  logic                        frame_start_i,
    input  logic                        sel_ram_i,
    input  logic                        page_i,
    input  logic                        cpu_req_i,
    input  logic [31:0]                 cpu_addr_i,
    output logic                        cpu_gnt_o,
    output logic                        mem_rd_o,
    output logic                        mem_sel_o,
    output logic [31:0]                 mem_addr_o,
    input  logic [31:0]                 mem_rdata_i,
    output logic                        buf_we_o,
    output logic [BUF_IDX_W(WORDS)-1:0] buf_idx_o,
    output logic [31:0]                 buf_data_o,
    output logic                        busy_o,
    output logic                        overrun_o
);

    localparam int L  = $clog2(WORDS);
    localparam int BW = BUF_IDX_W(WORDS);
    localparam int SW = $clog2(STARVE_MAX + 1);

    scan_state_e   state_q, state_d;
    logic [L-1:0]  idx_q, idx_d;
    logic [SW-1:0] starve_q, starve_d;
    logic          sel_q, sel_d;
    logic          page_q, page_d;
    logic          overrun_q, overrun_d;

    logic          buf_we_q;
    logic [BW-1:0] buf_idx_q;
    logic [31:0]   buf_data_q;

    logic          force_scan;
    logic          cpu_gnt;
    logic          scan_issue;
    logic          last_issue;
    logic [31:0]   scan_addr;

    logic          pipe_vld;
    logic          pipe_pending;
    logic [BW-1:0] pipe_tag;

    assign scan_addr = ((32'(page_q) * 32'(WORDS)) + 32'(idx_q)) << 2;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (frame_start_i) state_d = SCAN;
            SCAN:    if (last_issue)    state_d = DRAIN;
            DRAIN:   if (!pipe_pending) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Same-cycle grant: the CPU wins unless the scanner has been starved too long
    always_comb begin
        force_scan = 1'b0;
        cpu_gnt    = cpu_req_i;
        scan_issue = 1'b0;
        mem_rd_o   = cpu_req_i;
        mem_sel_o  = sel_ram_i;
        mem_addr_o = cpu_addr_i;
        if (state_q == SCAN) begin
            force_scan = (starve_q == SW'(STARVE_MAX));
            cpu_gnt    = cpu_req_i & ~force_scan;
            mem_rd_o   = 1'b1;
            if (!cpu_gnt) begin
                scan_issue = 1'b1;
                mem_sel_o  = sel_q;
                mem_addr_o = scan_addr;
            end
        end
    end

    assign cpu_gnt_o  = cpu_gnt;
    assign last_issue = scan_issue && (idx_q == L'(WORDS - 1));

    always_comb begin
        idx_d     = idx_q;
        starve_d  = starve_q;
        sel_d     = sel_q;
        page_d    = page_q;
        overrun_d = overrun_q;
        if (frame_start_i) begin
            if (state_q == IDLE) begin
                sel_d    = sel_ram_i ? MEM_SEL_RAM : MEM_SEL_ROM;
                page_d   = page_i;
                idx_d    = '0;
                starve_d = '0;
            end else begin
                overrun_d = 1'b1;
            end
        end
        if (scan_issue) begin
            idx_d    = last_issue ? '0 : idx_q + L'(1);
            starve_d = '0;
        end else if ((state_q == SCAN) && cpu_gnt) begin
            starve_d = starve_q + SW'(1);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            idx_q     <= '0;
            starve_q  <= '0;
            sel_q     <= MEM_SEL_ROM;
            page_q    <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            idx_q     <= idx_d;
            starve_q  <= starve_d;
            sel_q     <= sel_d;
            page_q    <= page_d;
            overrun_q <= overrun_d;
        end
    end

    vga_rd_tag_pipe #(
        .DEPTH (RD_LAT),
        .TAG_W (BW)
    ) u_tag_pipe (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .valid_i   (scan_issue),
        .tag_i     ({sel_q, page_q, idx_q}),
        .valid_o   (pipe_vld),
        .tag_o     (pipe_tag),
        .pending_o (pipe_pending)
    );

    // Tail of the pipe lines up with mem_rdata; CPU reads carry valid=0 and never write
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            buf_we_q   <= 1'b0;
            buf_idx_q  <= '0;
            buf_data_q <= '0;
        end else begin
            buf_we_q <= pipe_vld;
            if (pipe_vld) begin
                buf_idx_q  <= pipe_tag;
                buf_data_q <= mem_rdata_i;
            end
        end
    end

    assign buf_we_o   = buf_we_q;
    assign buf_idx_o  = buf_idx_q;
    assign buf_data_o = buf_data_q;
    assign busy_o     = (state_q != IDLE);
    assign overrun_o  = overrun_q;

endmodule
